multi_read_mem: RTL
===================

# multi_read_mem

Parametrised one-write, N-read synchronous memory with per-lane write enables, per-port read enables with valid flags, and an automatic zero-fill sequence after reset. It is the next-generation simple dual-port memory for register files, lookup tables and buffer storage where several consumers read one array. A configurable read-during-write policy makes same-address collisions deterministic.

## Interface
- ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH entries
- DATA_WIDTH, 8, word width; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 4, bits per write-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH
- NUM_READ, 2, number of read ports, ≥1
- clk  in  1  single clock; all logic on posedge clk
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable
- wa  in  ADDR_WIDTH  write address
- wd  in  DATA_WIDTH  write data
- wbe  in  NUM_LANES  lane write enables; lane i covers wd[i*LANE_WIDTH +: LANE_WIDTH]
- re  in  NUM_READ  per-port read enable
- ra  in  NUM_READ*ADDR_WIDTH  read addresses, port p at ra[p*ADDR_WIDTH +: ADDR_WIDTH]
- rd  out  NUM_READ*DATA_WIDTH  read data, port p at rd[p*DATA_WIDTH +: DATA_WIDTH]
- rvalid  out  NUM_READ  rd slice of port p is new this cycle
- init_busy  out  1  zero-fill in progress; all requests ignored

## Operation
- FSM states: INIT, READY. rst forces INIT with fill pointer 0.
- INIT: each cycle writes all-zero word to mem[ptr] and increments ptr. After writing DEPTH-1, next state is READY. init_busy = 1 throughout INIT. we, re, wa, ra, wd and wbe are ignored; rvalid stays 0.
- READY: a write with we=1 updates only lanes with wbe[i]=1. we=1 with wbe=0 is a no-op.
- Read port p with re[p]=1 samples ra[p]. The word appears on rd[p] the next cycle with rvalid[p]=1.
- re[p]=0 leaves rd[p] holding its last value and drives rvalid[p]=0.
- Ports are independent. Any number of ports may read the same address in one cycle.
- Read-during-write to the same address: behaviour depends on the configuration macro (see Configuration). A write and a read to different addresses never interact.
- rst mid-fill restarts the fill at address 0. rst in READY discards no stored state except through the new fill, which zeroes the whole array.

## Timing
- Reset values: rd = 0 on all ports, rvalid = 0, init_busy = 1 (registered; visible the cycle after rst is sampled).
- The fill takes exactly DEPTH cycles after rst deasserts. init_busy falls on the first READY cycle, and requests are accepted from that cycle.
- Read latency is 1 cycle: request sampled at edge k, rd/rvalid valid after edge k+1.
- Write latency is 1 cycle: data written at edge k is returned by a read sampled at edge k+1.
- rst and the write enable both sampled high: reset wins and the write is dropped.

## Configuration
- MULTI_READ_MEM_WRITE_FIRST_EN defined: a read sampled in the same cycle as a write to the same address returns the merged word. Lanes with wbe=1 come from wd; the remaining lanes come from the old content. Each read port has its own bypass compare and mux.
- Undefined: the same collision returns the old content (read-first). There is no bypass logic.

## Structure
- Package multi_read_mem_pkg holds:
  - state typedef (INIT, READY)
  - a function computing NUM_LANES
  - the lane-merge function used by both the write path and the bypass
- Sub-module mem_read_port, instantiated NUM_READ times by generate, contains:
  - address register
  - rvalid register
  - rd output register
  - optional bypass compare/merge
- The top level holds the array, the write logic and the fill FSM.

## Test plan
- Reset, then hold re=all-ones for DEPTH+2 cycles -> init_busy high exactly 64 cycles (defaults); rvalid=0 throughout; first READY read of address 5 returns 0x00.
- Write wa=3, wd=0xA5, wbe=2'b11; next cycle read port 0 ra=3 and port 1 ra=3 -> both rd=0xA5, rvalid=2'b11 one cycle later.
- mem[7]=0xA5, then write wa=7, wd=0x3C, wbe=2'b01; then read 7 -> rd=0xAC.
- mem[9]=0x11; same cycle write wa=9, wd=0xFF, wbe=2'b11 and read ra=9 -> rd=0xFF with WRITE_FIRST_EN, 0x11 without.
- Read port 0 at address 3, then deassert re[0] -> rd[0] holds 0xA5, rvalid[0]=0; port 1 reads address 4 concurrently unaffected.
- Assert rst at fill pointer 30 -> fill restarts at 0; init_busy stays high 64 more cycles; an earlier-written address reads 0 afterwards.

Source files
------------

// File: rtl/multi_read_mem_pkg.sv
// multi_read_mem_pkg
//   Shared types and helpers for multi_read_mem and mem_read_port:
//   fill FSM state type, lane-count function and the lane-merge function
//   used by both the array write path and the optional read bypass.
package multi_read_mem_pkg;

    typedef enum logic {
        INIT,
        READY
    } state_e;

    // lane_merge works on a fixed maximum width; callers zero-extend their
    // operands and truncate the result. Words wider than this are unsupported.
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_IDX_W  = $clog2(MAX_DATA_W);

    function automatic int unsigned num_lanes(input int unsigned data_w,
                                              input int unsigned lane_w);
        return data_w / lane_w;
    endfunction

    // Bit i takes new_word when its lane's enable is set, else old_word.
    function automatic logic [MAX_DATA_W-1:0] lane_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_DATA_W-1:0] be,
        input int unsigned           lane_w
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
            if (be[MAX_IDX_W'(i / lane_w)]) begin
                res[MAX_IDX_W'(i)] = new_word[MAX_IDX_W'(i)];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_read_port.sv
// mem_read_port
//   One registered read port of multi_read_mem. Looks up the array word at
//   ra_i, and on re_i loads it into the rd register with rvalid for one cycle.
//   With MULTI_READ_MEM_WRITE_FIRST_EN defined, a same-cycle write to the
//   same address is merged into the returned word (write-first); otherwise
//   the old content is returned (read-first) and the write-side ports and
//   LANE_WIDTH parameter do not exist.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   we_i/wa_i/wd_i/wbe_i  qualified write request (bypass build only)
//   re_i, ra_i        qualified read enable and address
//   mem_i             the storage array
//   rd_o, rvalid_o    registered read data and valid flag
module mem_read_port
    import multi_read_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
`ifdef MULTI_READ_MEM_WRITE_FIRST_EN
    ,
    parameter int unsigned LANE_WIDTH = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MULTI_READ_MEM_WRITE_FIRST_EN
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] wa_i,
    input  logic [DATA_WIDTH-1:0] wd_i,
    input  logic [num_lanes(DATA_WIDTH, LANE_WIDTH)-1:0] wbe_i,
`endif
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] ra_i,
    input  logic [DATA_WIDTH-1:0] mem_i [2**ADDR_WIDTH],
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  rvalid_o
);

    logic [DATA_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  rvalid_q;

    always_comb begin
        rd_d = mem_i[ra_i];
`ifdef MULTI_READ_MEM_WRITE_FIRST_EN
        if (we_i && (wa_i == ra_i)) begin
            rd_d = DATA_WIDTH'(lane_merge(MAX_DATA_W'(mem_i[ra_i]),
                                          MAX_DATA_W'(wd_i),
                                          MAX_DATA_W'(wbe_i),
                                          LANE_WIDTH));
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= re_i;
            if (re_i) begin
                rd_q <= rd_d;
            end
        end
    end

    assign rd_o     = rd_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/multi_read_mem.sv
// multi_read_mem
//   One-write, NUM_READ-read synchronous memory with per-lane write enables
//   and per-port registered reads. After reset the array is zero-filled, one
//   word per cycle, while init_busy is high and all requests are ignored.
//   Build option MULTI_READ_MEM_WRITE_FIRST_EN: same-address read-during-write
//   returns the merged new word; undefined, it returns the old word.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   we, wa, wd    write enable, address, data
//   wbe           per-lane write enables (LANE_WIDTH bits per lane)
//   re, ra        per-port read enables and packed read addresses
//   rd, rvalid    packed registered read data and per-port valid flags
//   init_busy     zero-fill in progress
module multi_read_mem
    import multi_read_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANE_WIDTH = 4,
    parameter int unsigned NUM_READ   = 2,
    localparam int unsigned NUM_LANES = num_lanes(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          wa,
    input  logic [DATA_WIDTH-1:0]          wd,
    input  logic [NUM_LANES-1:0]           wbe,
    input  logic [NUM_READ-1:0]            re,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ra,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd,
    output logic [NUM_READ-1:0]            rvalid,
    output logic                           init_busy
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    state_e                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic                  busy_q;

    logic                  ready;
    logic                  we_eff;
    logic [NUM_READ-1:0]   re_eff;
    logic [DATA_WIDTH-1:0] wr_word_d;

    assign ready  = (state_q == READY);
    assign we_eff = we & ready;
    assign re_eff = re & {NUM_READ{ready}};

    assign wr_word_d = DATA_WIDTH'(lane_merge(MAX_DATA_W'(mem_q[wa]),
                                              MAX_DATA_W'(wd),
                                              MAX_DATA_W'(wbe),
                                              LANE_WIDTH));

    // Fill FSM and array write port share one block so the fill and normal
    // writes can never both target the array in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    mem_q[ptr_q] <= '0;
                    ptr_q        <= ptr_q + ADDR_WIDTH'(1);
                    if (ptr_q == '1) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    if (we_eff) begin
                        mem_q[wa] <= wr_word_d;
                    end
                end
                default: begin
                    state_q <= INIT;
                    ptr_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign init_busy = busy_q;

    for (genvar p = 0; p < NUM_READ; p++) begin : g_port
        mem_read_port #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
`ifdef MULTI_READ_MEM_WRITE_FIRST_EN
            ,
            .LANE_WIDTH(LANE_WIDTH)
`endif
        ) u_port (
            .clk      (clk),
            .rst      (rst),
`ifdef MULTI_READ_MEM_WRITE_FIRST_EN
            .we_i     (we_eff),
            .wa_i     (wa),
            .wd_i     (wd),
            .wbe_i    (wbe),
`endif
            .re_i     (re_eff[p]),
            .ra_i     (ra[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .mem_i    (mem_q),
            .rd_o     (rd[p*DATA_WIDTH +: DATA_WIDTH]),
            .rvalid_o (rvalid[p])
        );
    end

endmodule
